// File: rtl/time_compare_unit.sv
// time_compare_unit: consumer end of the 64-bit real-time counter.
// Holds the 64-bit mtimecmp value, written as lo/hi halves over the 32-bit CSR path.
// Drives the machine timer interrupt (MTIP) from a DISARMED/ARMED/FIRED state machine.
// Serves 32-bit reads of time and timecmp to the CSR unit.
// Build option TIME_SNAPSHOT_EN: when defined, a time_lo read captures time_hi into a
// shadow register, and a later time_hi read returns that shadow. This keeps a lo-then-hi
// read pair consistent across a carry out of bit 31. When the option is undefined,
// time_hi reads return the live counter value.
module time_compare_unit #(
    parameter int COUNT_LEN = 64,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COUNT_LEN-1:0] time_in,
    input  logic                 csr_we,
    input  logic                 csr_re,
    input  logic [1:0]           csr_sel,
    input  logic [XLEN-1:0]      csr_wdata,
    output logic [XLEN-1:0]      csr_rdata,
    output logic                 csr_rvalid,
    output logic                 timer_irq,
    output logic                 cmp_armed
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FIRED    = 2'd2
    } state_t;

    localparam logic [1:0] SEL_CMP_LO  = 2'd0;
    localparam logic [1:0] SEL_CMP_HI  = 2'd1;
    localparam logic [1:0] SEL_TIME_LO = 2'd2;
    localparam logic [1:0] SEL_TIME_HI = 2'd3;

    state_t                 state_r;
    logic [COUNT_LEN-1:0]   cmp_r;
    logic                   time_ge_cmp_s;
    logic [XLEN-1:0]        time_hi_s;
    logic [XLEN-1:0]        rdata_next_s;

    // Full-width unsigned compare against the registered compare value; no modular wrap.
    assign time_ge_cmp_s = (time_in >= cmp_r);

`ifdef TIME_SNAPSHOT_EN
    logic [XLEN-1:0]        time_hi_shadow_r;

    // Capture the upper counter half whenever software reads the lower half.
    always_ff @(posedge clk) begin
        if (rst) begin
            time_hi_shadow_r <= {XLEN{1'b0}};
        end else if (csr_re && (csr_sel == SEL_TIME_LO)) begin
            time_hi_shadow_r <= time_in[COUNT_LEN-1:XLEN];
        end else begin
            time_hi_shadow_r <= time_hi_shadow_r;
        end
    end

    assign time_hi_s = time_hi_shadow_r;
`else
    assign time_hi_s = time_in[COUNT_LEN-1:XLEN];
`endif

    // Select the read data from the pre-write register contents.
    always_comb begin
        rdata_next_s = {XLEN{1'b0}};
        case (csr_sel)
            SEL_CMP_LO:  rdata_next_s = cmp_r[XLEN-1:0];
            SEL_CMP_HI:  rdata_next_s = cmp_r[COUNT_LEN-1:XLEN];
            SEL_TIME_LO: rdata_next_s = time_in[XLEN-1:0];
            SEL_TIME_HI: rdata_next_s = time_hi_s;
            default:     rdata_next_s = {XLEN{1'b0}};
        endcase
    end

    // Compare register: reset to all ones so that a cleared compare never fires early.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_r <= {COUNT_LEN{1'b1}};
        end else if (csr_we) begin
            case (csr_sel)
                SEL_CMP_LO: cmp_r[XLEN-1:0]         <= csr_wdata;
                SEL_CMP_HI: cmp_r[COUNT_LEN-1:XLEN] <= csr_wdata;
                default:    cmp_r                   <= cmp_r;
            endcase
        end else begin
            cmp_r <= cmp_r;
        end
    end

    // Read port: data and valid are registered one cycle after the strobe; data holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_rdata  <= {XLEN{1'b0}};
            csr_rvalid <= 1'b0;
        end else if (csr_re) begin
            csr_rdata  <= rdata_next_s;
            csr_rvalid <= 1'b1;
        end else begin
            csr_rdata  <= csr_rdata;
            csr_rvalid <= 1'b0;
        end
    end

    // Compare FSM: the outputs are registered together with the state they decode.
    // A cmp_lo write disarms, so that a lo/hi update sequence cannot raise a spurious IRQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_DISARMED;
            timer_irq <= 1'b0;
            cmp_armed <= 1'b0;
        end else if (csr_we && (csr_sel == SEL_CMP_LO)) begin
            state_r   <= ST_DISARMED;
            timer_irq <= 1'b0;
            cmp_armed <= 1'b0;
        end else if (csr_we && (csr_sel == SEL_CMP_HI)) begin
            state_r   <= ST_ARMED;
            timer_irq <= 1'b0;
            cmp_armed <= 1'b1;
        end else begin
            case (state_r)
                ST_DISARMED: begin
                    state_r   <= ST_DISARMED;
                    timer_irq <= 1'b0;
                    cmp_armed <= 1'b0;
                end
                ST_ARMED: begin
                    if (time_ge_cmp_s) begin
                        state_r   <= ST_FIRED;
                        timer_irq <= 1'b1;
                    end else begin
                        state_r   <= ST_ARMED;
                        timer_irq <= 1'b0;
                    end
                    cmp_armed <= 1'b1;
                end
                ST_FIRED: begin
                    if (time_ge_cmp_s) begin
                        state_r   <= ST_FIRED;
                        timer_irq <= 1'b1;
                    end else begin
                        state_r   <= ST_ARMED;
                        timer_irq <= 1'b0;
                    end
                    cmp_armed <= 1'b1;
                end
                default: begin
                    state_r   <= ST_DISARMED;
                    timer_irq <= 1'b0;
                    cmp_armed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_compare_unit.sv
// Directed testbench for time_compare_unit with hand-computed expected values.
// Inputs change 1 ns after the rising edge. Outputs are sampled at that same point.
module tb_time_compare_unit;

    logic        clk;
    logic        rst;
    logic [63:0] time_in;
    logic        csr_we;
    logic        csr_re;
    logic [1:0]  csr_sel;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        timer_irq;
    logic        cmp_armed;

    int tests_run;
    int tests_failed;

    time_compare_unit #(.COUNT_LEN(64), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .time_in    (time_in),
        .csr_we     (csr_we),
        .csr_re     (csr_re),
        .csr_sel    (csr_sel),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .csr_rvalid (csr_rvalid),
        .timer_irq  (timer_irq),
        .cmp_armed  (cmp_armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] data);
        csr_we    = 1'b1;
        csr_sel   = sel;
        csr_wdata = data;
        step();
        csr_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel);
        csr_re  = 1'b1;
        csr_sel = sel;
        step();
        csr_re  = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        time_in   = 64'd0;
        csr_we    = 1'b0;
        csr_re    = 1'b0;
        csr_sel   = 2'd0;
        csr_wdata = 32'd0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_irq",    {63'd0, timer_irq},  64'd0);
        check("rst_armed",  {63'd0, cmp_armed},  64'd0);
        check("rst_rvalid", {63'd0, csr_rvalid}, 64'd0);
        check("rst_rdata",  {32'd0, csr_rdata},  64'd0);
        step();
        check("idle_irq",   {63'd0, timer_irq},  64'd0);
        rd(2'd1);
        check("rd_hi_rvalid", {63'd0, csr_rvalid}, 64'd1);
        check("rd_hi_reset",  {32'd0, csr_rdata},  64'hFFFF_FFFF);
        step();
        check("rvalid_pulse", {63'd0, csr_rvalid}, 64'd0);
        check("rdata_hold",   {32'd0, csr_rdata},  64'hFFFF_FFFF);

        // Arm at cmp=100 and step the time through the compare value
        wr(2'd0, 32'd100);
        check("lo_disarm", {63'd0, cmp_armed}, 64'd0);
        wr(2'd1, 32'd0);
        check("hi_arm",     {63'd0, cmp_armed}, 64'd1);
        check("hi_arm_irq", {63'd0, timer_irq}, 64'd0);
        time_in = 64'd98;
        step();
        check("t98_irq",   {63'd0, timer_irq}, 64'd0);
        check("t98_armed", {63'd0, cmp_armed}, 64'd1);
        time_in = 64'd99;
        step();
        check("t99_irq", {63'd0, timer_irq}, 64'd0);
        time_in = 64'd100;
        check("t100_pre_irq", {63'd0, timer_irq}, 64'd0);
        step();
        check("t100_irq",   {63'd0, timer_irq}, 64'd1);
        check("t100_armed", {63'd0, cmp_armed}, 64'd1);

        // Rewrite the compare value while FIRED
        time_in = 64'd150;
        step();
        check("t150_irq", {63'd0, timer_irq}, 64'd1);
        wr(2'd0, 32'h200);
        check("relo_irq",   {63'd0, timer_irq}, 64'd0);
        check("relo_armed", {63'd0, cmp_armed}, 64'd0);
        step();
        check("disarm_stays", {63'd0, cmp_armed}, 64'd0);
        wr(2'd1, 32'd0);
        check("rehi_armed", {63'd0, cmp_armed}, 64'd1);
        check("rehi_irq",   {63'd0, timer_irq}, 64'd0);
        step();
        check("t150_below", {63'd0, timer_irq}, 64'd0);
        time_in = 64'h200;
        check("t200_pre", {63'd0, timer_irq}, 64'd0);
        step();
        check("t200_irq", {63'd0, timer_irq}, 64'd1);

        // Counter wrap to 0 while FIRED
        time_in = 64'd0;
        step();
        check("wrap_irq",   {63'd0, timer_irq}, 64'd0);
        check("wrap_armed", {63'd0, cmp_armed}, 64'd1);

        // cmp = all ones fires only at time = all ones
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        time_in = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        check("max_m1_irq", {63'd0, timer_irq}, 64'd0);
        time_in = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        check("max_irq", {63'd0, timer_irq}, 64'd1);

        // Lo-then-hi time read across a carry out of bit 31
        time_in = 64'h0000_0001_FFFF_FFFF;
        rd(2'd2);
        check("time_lo", {32'd0, csr_rdata}, 64'hFFFF_FFFF);
        time_in = 64'h0000_0002_0000_0000;
        rd(2'd3);
`ifdef TIME_SNAPSHOT_EN
        check("time_hi_snap", {32'd0, csr_rdata}, 64'h1);
`else
        check("time_hi_live", {32'd0, csr_rdata}, 64'h2);
`endif

        // Read and write to the same register in one cycle
        wr(2'd0, 32'd5);
        csr_we    = 1'b1;
        csr_re    = 1'b1;
        csr_sel   = 2'd0;
        csr_wdata = 32'd9;
        step();
        csr_we = 1'b0;
        csr_re = 1'b0;
        check("rw_old",    {32'd0, csr_rdata},  64'd5);
        check("rw_rvalid", {63'd0, csr_rvalid}, 64'd1);
        rd(2'd0);
        check("rw_new", {32'd0, csr_rdata}, 64'd9);

        // Reset while FIRED with a read in flight
        wr(2'd1, 32'd0);
        time_in = 64'd100;
        step();
        check("pre_rst_irq", {63'd0, timer_irq}, 64'd1);
        rst     = 1'b1;
        csr_re  = 1'b1;
        csr_sel = 2'd0;
        step();
        rst    = 1'b0;
        csr_re = 1'b0;
        check("mid_rst_irq",    {63'd0, timer_irq},  64'd0);
        check("mid_rst_rvalid", {63'd0, csr_rvalid}, 64'd0);
        check("mid_rst_armed",  {63'd0, cmp_armed},  64'd0);
        rd(2'd0);
        check("mid_rst_cmp_lo", {32'd0, csr_rdata}, 64'hFFFF_FFFF);
        rd(2'd1);
        check("mid_rst_cmp_hi", {32'd0, csr_rdata}, 64'hFFFF_FFFF);
        step();
        check("mid_rst_no_fire", {63'd0, timer_irq}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
